// File: rtl/correlator_pkg.sv
// correlator_pkg: definitions shared by the correlator host command path.
// Holds the command opcodes, the default integration period, the FSM state
// types, and the helper that derives the baud divider from the clock rate.
package correlator_pkg;

  localparam logic [7:0]  OP_INTEG    = 8'h01;
  localparam logic [7:0]  OP_MASK     = 8'h02;
  localparam logic [7:0]  OP_DELAY    = 8'h03;
  localparam logic [7:0]  OP_DEFAULTS = 8'h7F;

  localparam logic [15:0] DEF_INTEG   = 16'h0400;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    P_IDLE, P_GOT_OP, P_GOT_HI, P_GOT_LO
  } parse_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial byte receiver.
//   clk, reset_n  system clock, async active-low reset
//   rx            raw serial line, idle high, asynchronous to clk
//   byte_valid    1-cycle pulse, byte_data holds the received byte
//   byte_data     last received byte, LSB arrived first
//   frame_err     1-cycle pulse when the stop bit is sampled low
//
// state        | meaning
// RX_IDLE      | waiting for a falling edge on the synchronised line
// RX_START     | counting to mid start bit to reject glitches
// RX_DATA      | sampling 8 data bits, one per bit time
// RX_STOP      | sampling the stop bit
// RX_WAIT_HIGH | bad stop bit seen; waiting for the line to return high
module uart_rx_byte
  import correlator_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (!rx_sync_q) begin
          state_d = RX_DATA;
          cnt_d   = BIT_LOAD;
          bit_d   = 3'd0;
        end else state_d = RX_IDLE;
      end
      RX_DATA: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (rx_sync_q) begin
          byte_valid_d = 1'b1;
          state_d      = RX_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        // a held-low line (break) must not look like a string of start bits
        if (rx_sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/correlator_cmd_rx.sv
// correlator_cmd_rx: host command receiver for the correlator.
// Parses 4-byte frames (opcode, data_hi, data_lo, csum) from the serial link
// and updates the runtime configuration registers.
//   clk, reset_n      system clock, async active-low reset
//   RX                serial input, 8N1, idle high
//   integration_time  integration period register
//   channel_mask      per-input enable mask
//   delay_sel         delay tap select, saturated at MAX_DELAY
//   cmd_valid         1-cycle pulse on an accepted frame, with the update
//   cmd_code          opcode of the last accepted frame
//   frame_err         1-cycle pulse on a bad stop bit
//   csum_err          1-cycle pulse on a rejected frame
//
// state    | meaning
// P_IDLE   | waiting for an opcode byte
// P_GOT_OP | opcode held, waiting for data_hi
// P_GOT_HI | data_hi held, waiting for data_lo
// P_GOT_LO | data_lo held, next byte is the checksum
module correlator_cmd_rx #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 230400,
  parameter int NUM_INPUTS    = 12,
  parameter int RESOLUTION    = 16,
  parameter int MAX_DELAY     = 1,
  parameter int TIMEOUT_BITS  = 20,
  parameter logic [RESOLUTION-1:0] DEF_INTEG = RESOLUTION'(correlator_pkg::DEF_INTEG)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  RX,
  output logic [RESOLUTION-1:0] integration_time,
  output logic [NUM_INPUTS-1:0] channel_mask,
  output logic [7:0]            delay_sel,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_code,
  output logic                  frame_err,
  output logic                  csum_err
);
  import correlator_pkg::*;

  localparam int CPB = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
  localparam int CW  = $clog2(CPB + 1);
  localparam int TW  = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] BIT_LOAD     = CW'(CPB - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_BITS);
  localparam logic [7:0]    MAX_DELAY_B  = 8'(MAX_DELAY);

  logic       byte_valid, rx_frame_err;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (RX),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (rx_frame_err)
  );

  parse_state_e          pstate_q, pstate_d, cur_state;
  logic [7:0]            op_q, op_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]         bt_q, bt_d;
  logic [TW-1:0]         gap_q, gap_d;
  logic [RESOLUTION-1:0] integ_q, integ_d;
  logic [NUM_INPUTS-1:0] mask_q, mask_d;
  logic [7:0]            delay_q, delay_d, code_q, code_d;
  logic                  cmd_valid_q, cmd_valid_d, csum_err_q, csum_err_d;
  logic                  accept;
  logic [15:0]           data_w;

  assign data_w = {hi_q, lo_q};

  // Inter-byte gap: bt counts clocks of one bit time, gap counts bit times down.
  always_comb begin
    bt_d  = bt_q;
    gap_d = gap_q;
    if (byte_valid) begin
      bt_d  = BIT_LOAD;
      gap_d = TIMEOUT_LOAD;
    end else if (bt_q == '0) begin
      bt_d = BIT_LOAD;
      if (gap_q != '0) gap_d = gap_q - 1'b1;
    end else bt_d = bt_q - 1'b1;
  end

  always_comb begin
    integ_d     = integ_q;
    mask_d      = mask_q;
    delay_d     = delay_q;
    code_d      = code_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cmd_valid_d = 1'b0;
    csum_err_d  = 1'b0;
    accept      = 1'b0;
    // a timeout or framing error drops any partial frame; a byte arriving in
    // that same cycle is then treated as a fresh opcode
    cur_state = (gap_q == '0 || rx_frame_err) ? P_IDLE : pstate_q;
    pstate_d  = cur_state;
    if (byte_valid) begin
      case (cur_state)
        P_IDLE:   begin op_d = byte_data; pstate_d = P_GOT_OP; end
        P_GOT_OP: begin hi_d = byte_data; pstate_d = P_GOT_HI; end
        P_GOT_HI: begin lo_d = byte_data; pstate_d = P_GOT_LO; end
        P_GOT_LO: begin
          pstate_d = P_IDLE;
          if (byte_data == (op_q ^ hi_q ^ lo_q)) begin
            case (op_q)
              OP_INTEG: begin
                if (RESOLUTION'(data_w) != '0) begin
                  integ_d = RESOLUTION'(data_w);
                  accept  = 1'b1;
                end
              end
              OP_MASK: begin
                mask_d = NUM_INPUTS'(data_w);
                accept = 1'b1;
              end
              OP_DELAY: begin
                delay_d = (lo_q > MAX_DELAY_B) ? MAX_DELAY_B : lo_q;
                accept  = 1'b1;
              end
              OP_DEFAULTS: begin
                integ_d = DEF_INTEG;
                mask_d  = '1;
                delay_d = 8'h00;
                accept  = 1'b1;
              end
              default: accept = 1'b0;
            endcase
          end
          if (accept) begin
            code_d      = op_q;
            cmd_valid_d = 1'b1;
          end else csum_err_d = 1'b1;
        end
        default: pstate_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pstate_q    <= P_IDLE;
      op_q        <= 8'h00;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      bt_q        <= BIT_LOAD;
      gap_q       <= TIMEOUT_LOAD;
      integ_q     <= DEF_INTEG;
      mask_q      <= '1;
      delay_q     <= 8'h00;
      code_q      <= 8'h00;
      cmd_valid_q <= 1'b0;
      csum_err_q  <= 1'b0;
    end else begin
      pstate_q    <= pstate_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      bt_q        <= bt_d;
      gap_q       <= gap_d;
      integ_q     <= integ_d;
      mask_q      <= mask_d;
      delay_q     <= delay_d;
      code_q      <= code_d;
      cmd_valid_q <= cmd_valid_d;
      csum_err_q  <= csum_err_d;
    end
  end

  assign integration_time = integ_q;
  assign channel_mask     = mask_q;
  assign delay_sel        = delay_q;
  assign cmd_code         = code_q;
  assign cmd_valid        = cmd_valid_q;
  assign csum_err         = csum_err_q;
  assign frame_err        = rx_frame_err;

endmodule

// File: tb/tb_correlator_cmd_rx.sv
// Bench for correlator_cmd_rx: directed frame table plus hand-written
// sequences for timeout, framing error, glitch and mid-frame reset.
// The clock rate is chosen so one bit time at 230400 baud is 20 clocks.
module tb_correlator_cmd_rx;

  localparam int CPB = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RX;
  logic [15:0] integration_time;
  logic [11:0] channel_mask;
  logic [7:0]  delay_sel;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        frame_err;
  logic        csum_err;

  correlator_cmd_rx #(
    .CLK_FREQUENCY (4608000),
    .BAUD_RATE     (230400)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .RX               (RX),
    .integration_time (integration_time),
    .channel_mask     (channel_mask),
    .delay_sel        (delay_sel),
    .cmd_valid        (cmd_valid),
    .cmd_code         (cmd_code),
    .frame_err        (frame_err),
    .csum_err         (csum_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // pulse monitor
  int n_bv = 0, n_valid = 0, n_cerr = 0, n_ferr = 0;
  int overlap_err = 0, lat_err = 0, width_err = 0;
  logic        prev_bv = 1'b0, prev_valid = 1'b0;
  logic [15:0] last_integ = 16'h0, cap_integ = 16'h0, pre_integ = 16'h0;
  logic [11:0] cap_mask = 12'h0;
  logic [7:0]  cap_delay = 8'h0;

  always @(negedge clk) begin
    if (dut.u_rx.byte_valid) n_bv++;
    if (cmd_valid) n_valid++;
    if (csum_err) n_cerr++;
    if (frame_err) n_ferr++;
    if (int'(cmd_valid) + int'(csum_err) + int'(frame_err) > 1) overlap_err++;
    if ((cmd_valid || csum_err) && !prev_bv) lat_err++;
    if (cmd_valid && prev_valid) width_err++;
    if (cmd_valid) begin
      cap_integ = integration_time;
      cap_mask  = channel_mask;
      cap_delay = delay_sel;
      pre_integ = last_integ;
    end
    last_integ = integration_time;
    prev_bv    = dut.u_rx.byte_valid;
    prev_valid = cmd_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_clks(CPB);
    end
    RX = stop_bit;
    wait_clks(CPB);
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    wait_clks(n * CPB);
  endtask

  task automatic send_frame(input logic [7:0] op, hi, lo, cs);
    send_byte(op, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    send_byte(cs, 1'b1);
    idle_bits(2);
  endtask

  typedef struct {
    logic [7:0]  op, hi, lo, cs;
    int          exp_valid, exp_cerr;
    logic [15:0] integ;
    logic [11:0] mask;
    logic [7:0]  dly, code;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int b_v, b_c, b_f, b_bv;
    logic [15:0] prior_integ;

    vecs[0]  = '{8'h01, 8'h12, 8'h34, 8'h27, 1, 0, 16'h1234, 12'hFFF, 8'h00, 8'h01};
    vecs[1]  = '{8'h02, 8'h0A, 8'h5C, 8'h54, 1, 0, 16'h1234, 12'hA5C, 8'h00, 8'h02};
    vecs[2]  = '{8'h03, 8'h00, 8'h09, 8'h0A, 1, 0, 16'h1234, 12'hA5C, 8'h01, 8'h03};
    vecs[3]  = '{8'h01, 8'h12, 8'h34, 8'h26, 0, 1, 16'h1234, 12'hA5C, 8'h01, 8'h03};
    vecs[4]  = '{8'h01, 8'h00, 8'h00, 8'h01, 0, 1, 16'h1234, 12'hA5C, 8'h01, 8'h03};
    vecs[5]  = '{8'h03, 8'h00, 8'h00, 8'h03, 1, 0, 16'h1234, 12'hA5C, 8'h00, 8'h03};
    vecs[6]  = '{8'h03, 8'h00, 8'h01, 8'h02, 1, 0, 16'h1234, 12'hA5C, 8'h01, 8'h03};
    vecs[7]  = '{8'h05, 8'h00, 8'h00, 8'h05, 0, 1, 16'h1234, 12'hA5C, 8'h01, 8'h03};
    vecs[8]  = '{8'h02, 8'hFF, 8'hF0, 8'h0D, 1, 0, 16'h1234, 12'hFF0, 8'h01, 8'h02};
    vecs[9]  = '{8'h7F, 8'h00, 8'h00, 8'h7F, 1, 0, 16'h0400, 12'hFFF, 8'h00, 8'h7F};
    vecs[10] = '{8'h01, 8'hFF, 8'hFF, 8'h01, 1, 0, 16'hFFFF, 12'hFFF, 8'h00, 8'h01};

    RX = 1'b1;
    reset_n = 1'b0;
    wait_clks(5);
    chk("reset integ", 32'(integration_time), 32'h0400);
    chk("reset mask", 32'(channel_mask), 32'hFFF);
    chk("reset delay", 32'(delay_sel), 32'h0);
    chk("reset code", 32'(cmd_code), 32'h0);
    chk("reset pulses", {29'd0, cmd_valid, csum_err, frame_err}, 32'h0);
    reset_n = 1'b1;
    wait_clks(5);

    prior_integ = 16'h0400;
    for (int i = 0; i < 11; i++) begin
      b_v = n_valid; b_c = n_cerr;
      send_frame(vecs[i].op, vecs[i].hi, vecs[i].lo, vecs[i].cs);
      chk($sformatf("vec%0d cmd_valid count", i), 32'(n_valid - b_v), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d csum_err count", i), 32'(n_cerr - b_c), 32'(vecs[i].exp_cerr));
      chk($sformatf("vec%0d integ", i), 32'(integration_time), 32'(vecs[i].integ));
      chk($sformatf("vec%0d mask", i), 32'(channel_mask), 32'(vecs[i].mask));
      chk($sformatf("vec%0d delay", i), 32'(delay_sel), 32'(vecs[i].dly));
      chk($sformatf("vec%0d code", i), 32'(cmd_code), 32'(vecs[i].code));
      if (vecs[i].exp_valid == 1) begin
        chk($sformatf("vec%0d integ at pulse", i), 32'(cap_integ), 32'(vecs[i].integ));
        chk($sformatf("vec%0d mask at pulse", i), 32'(cap_mask), 32'(vecs[i].mask));
        chk($sformatf("vec%0d delay at pulse", i), 32'(cap_delay), 32'(vecs[i].dly));
        chk($sformatf("vec%0d integ before pulse", i), 32'(pre_integ), 32'(prior_integ));
      end
      prior_integ = vecs[i].integ;
    end

    // short inter-byte gap is tolerated
    b_v = n_valid;
    send_byte(8'h01, 1'b1); send_byte(8'h12, 1'b1);
    idle_bits(5);
    send_byte(8'h34, 1'b1); send_byte(8'h27, 1'b1);
    idle_bits(2);
    chk("short gap accepted", 32'(n_valid - b_v), 32'd1);
    chk("short gap integ", 32'(integration_time), 32'h1234);

    // long gap drops the partial frame
    b_v = n_valid; b_c = n_cerr;
    send_byte(8'h01, 1'b1); send_byte(8'h12, 1'b1);
    idle_bits(25);
    send_frame(8'h01, 8'hAB, 8'hCD, 8'h67);
    chk("timeout valid count", 32'(n_valid - b_v), 32'd1);
    chk("timeout no csum_err", 32'(n_cerr - b_c), 32'd0);
    chk("timeout integ", 32'(integration_time), 32'hABCD);

    // bad stop bit mid-frame, then a break, then a good frame
    b_v = n_valid; b_c = n_cerr; b_f = n_ferr; b_bv = n_bv;
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    RX = 1'b0;
    wait_clks(30 * CPB);
    idle_bits(2);
    send_frame(8'h02, 8'h12, 8'h34, 8'h24);
    chk("break frame_err count", 32'(n_ferr - b_f), 32'd1);
    chk("break byte count", 32'(n_bv - b_bv), 32'd5);
    chk("break valid count", 32'(n_valid - b_v), 32'd1);
    chk("break csum_err count", 32'(n_cerr - b_c), 32'd0);
    chk("break mask", 32'(channel_mask), 32'h234);

    // 2-cycle glitch
    b_f = n_ferr; b_bv = n_bv;
    RX = 1'b0;
    wait_clks(2);
    idle_bits(3);
    chk("glitch byte count", 32'(n_bv - b_bv), 32'd0);
    chk("glitch frame_err count", 32'(n_ferr - b_f), 32'd0);

    // reset during data_lo
    send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
    RX = 1'b0;
    wait_clks(CPB);
    RX = 1'b1;
    wait_clks(CPB / 2);
    reset_n = 1'b0;
    wait_clks(3);
    chk("midreset integ", 32'(integration_time), 32'h0400);
    chk("midreset mask", 32'(channel_mask), 32'hFFF);
    chk("midreset delay", 32'(delay_sel), 32'h0);
    chk("midreset code", 32'(cmd_code), 32'h0);
    chk("midreset pulses", {29'd0, cmd_valid, csum_err, frame_err}, 32'h0);
    RX = 1'b1;
    wait_clks(2);
    reset_n = 1'b1;
    idle_bits(2);
    b_v = n_valid; b_c = n_cerr;
    send_frame(8'h03, 8'h00, 8'h01, 8'h02);
    chk("post-reset valid count", 32'(n_valid - b_v), 32'd1);
    chk("post-reset csum_err count", 32'(n_cerr - b_c), 32'd0);
    chk("post-reset delay", 32'(delay_sel), 32'h1);
    chk("post-reset code", 32'(cmd_code), 32'h03);

    chk("pulse overlap", 32'(overlap_err), 32'd0);
    chk("pulse latency after byte", 32'(lat_err), 32'd0);
    chk("cmd_valid width", 32'(width_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
